// File: rtl/ccip_mem_responder.sv
// CCI-P style line-store responder: read/write requests are serviced from a local
// store and answered through per-channel response FIFOs. Macro CCIP_MEM_RSP_INIT_EN zero-fills the store in INIT.

module ccip_mem_rsp_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ALM_THRESH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             stall_i,
  output logic             pop_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             alm_full_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    free;

  assign data_o = mem_q[rd_ptr_q];

  always_comb begin
    pop_o      = (cnt_q != '0) && !stall_i;
    full_o     = (cnt_q == CW'(DEPTH));
    free       = CW'(DEPTH) - cnt_q;
    alm_full_o = (free <= CW'(ALM_THRESH));
    wr_ptr_d   = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_o  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d      = cnt_q + CW'(push_i) - CW'(pop_o);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module ccip_mem_responder #(
  parameter int unsigned DEPTH_LOG2      = 6,
  parameter int unsigned RSP_FIFO_DEPTH  = 8,
  parameter int unsigned ALM_FULL_THRESH = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          c0_req_valid,
  input  logic [41:0]   c0_req_addr,
  input  logic [15:0]   c0_req_mdata,
  input  logic          c1_req_valid,
  input  logic [41:0]   c1_req_addr,
  input  logic [15:0]   c1_req_mdata,
  input  logic [511:0]  c1_req_data,
  output logic          c0_tx_alm_full,
  output logic          c1_tx_alm_full,
  output logic          c0_rsp_valid,
  output logic [15:0]   c0_rsp_mdata,
  output logic [511:0]  c0_rsp_data,
  output logic          c1_rsp_valid,
  output logic [15:0]   c1_rsp_mdata,
  output logic          ovf
);
  localparam int unsigned LINES = 1 << DEPTH_LOG2;

  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;

  logic [511:0]          store_q [LINES];
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
  logic                  unused_addr_hi;
  logic                  c0_drain_stall, c1_drain_stall;
  logic                  c0_push, c1_push, c0_pop, c1_pop;
  logic                  c0_full, c1_full, c0_alm, c1_alm;
  logic [527:0]          c0_head;
  logic [15:0]           c1_head;
  logic                  ovf_q, ovf_d;
  logic                  c0_rsp_valid_q, c1_rsp_valid_q;
  logic [15:0]           c0_rsp_mdata_q, c1_rsp_mdata_q;
  logic [511:0]          c0_rsp_data_q;
`ifdef CCIP_MEM_RSP_INIT_EN
  logic [DEPTH_LOG2-1:0] init_idx_q, init_idx_d;
`endif

  // Drain-stall hooks: tied off here; a wrapper may hold a FIFO's drain to emulate host backpressure.
  assign c0_drain_stall = 1'b0;
  assign c1_drain_stall = 1'b0;

  assign rd_idx         = c0_req_addr[DEPTH_LOG2-1:0];
  assign wr_idx         = c1_req_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^{c0_req_addr[41:DEPTH_LOG2], c1_req_addr[41:DEPTH_LOG2]};

  always_comb begin
    state_d = state_q;
`ifdef CCIP_MEM_RSP_INIT_EN
    init_idx_d = init_idx_q;
    if (state_q == INIT) begin
      init_idx_d = init_idx_q + DEPTH_LOG2'(1);
      if (init_idx_q == '1) state_d = RUN;
    end
`else
    if (state_q == INIT) state_d = RUN;
`endif
    // A full FIFO still takes a push when its head leaves in the same cycle.
    c0_push = c0_req_valid && (state_q == RUN) && (!c0_full || c0_pop);
    c1_push = c1_req_valid && (state_q == RUN) && (!c1_full || c1_pop);
    ovf_d   = ovf_q || (c0_req_valid && !c0_push) || (c1_req_valid && !c1_push);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= INIT;
      ovf_q          <= 1'b0;
      c0_rsp_valid_q <= 1'b0;
      c1_rsp_valid_q <= 1'b0;
`ifdef CCIP_MEM_RSP_INIT_EN
      init_idx_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ovf_q          <= ovf_d;
      c0_rsp_valid_q <= c0_pop;
      c1_rsp_valid_q <= c1_pop;
`ifdef CCIP_MEM_RSP_INIT_EN
      init_idx_q     <= init_idx_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
`ifdef CCIP_MEM_RSP_INIT_EN
    if (state_q == INIT) store_q[init_idx_q] <= '0;
    else
`endif
    if (c1_push) store_q[wr_idx] <= c1_req_data;
  end

  always_ff @(posedge clk) begin
    if (c0_pop) {c0_rsp_mdata_q, c0_rsp_data_q} <= c0_head;
    if (c1_pop) c1_rsp_mdata_q <= c1_head;
  end

  ccip_mem_rsp_fifo #(
    .WIDTH      (528),
    .DEPTH      (RSP_FIFO_DEPTH),
    .ALM_THRESH (ALM_FULL_THRESH)
  ) u_c0_fifo (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .push_i     (c0_push),
    .data_i     ({c0_req_mdata, store_q[rd_idx]}),
    .stall_i    (c0_drain_stall),
    .pop_o      (c0_pop),
    .data_o     (c0_head),
    .full_o     (c0_full),
    .alm_full_o (c0_alm)
  );

  ccip_mem_rsp_fifo #(
    .WIDTH      (16),
    .DEPTH      (RSP_FIFO_DEPTH),
    .ALM_THRESH (ALM_FULL_THRESH)
  ) u_c1_fifo (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .push_i     (c1_push),
    .data_i     (c1_req_mdata),
    .stall_i    (c1_drain_stall),
    .pop_o      (c1_pop),
    .data_o     (c1_head),
    .full_o     (c1_full),
    .alm_full_o (c1_alm)
  );

  assign c0_tx_alm_full = (state_q == INIT) || c0_alm;
  assign c1_tx_alm_full = (state_q == INIT) || c1_alm;
  assign c0_rsp_valid   = c0_rsp_valid_q;
  assign c0_rsp_mdata   = c0_rsp_mdata_q;
  assign c0_rsp_data    = c0_rsp_data_q;
  assign c1_rsp_valid   = c1_rsp_valid_q;
  assign c1_rsp_mdata   = c1_rsp_mdata_q;
  assign ovf            = ovf_q;
endmodule

// File: doc/ccip_mem_responder.md
CCIP_MEM_RESPONDER -- requirements
Module: ccip_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, giving a line store of 2^DEPTH_LOG2 cache lines of 512 bits.
REQ-002 SHALL have parameter RSP_FIFO_DEPTH, default 8, giving entries per response FIFO (power of 2).
REQ-003 SHALL have parameter ALM_FULL_THRESH, default 2, giving free entries at or below which almost-full asserts.
REQ-004 SHALL have these ports, with one clock and an asynchronous, active-low reset:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- c0_req_valid  in  1  read request strobe
- c0_req_addr  in  42  cache-line read address
- c0_req_mdata  in  16  read request tag
- c1_req_valid  in  1  write request strobe
- c1_req_addr  in  42  cache-line write address
- c1_req_mdata  in  16  write request tag
- c1_req_data  in  512  write data
- c0_tx_alm_full  out  1  read channel almost-full
- c1_tx_alm_full  out  1  write channel almost-full
- c0_rsp_valid  out  1  read response strobe
- c0_rsp_mdata  out  16  returned read tag
- c0_rsp_data  out  512  read data
- c1_rsp_valid  out  1  write response strobe
- c1_rsp_mdata  out  16  returned write tag
- ovf  out  1  sticky dropped-request flag

Function
REQ-005 SHALL index the store with addr[DEPTH_LOG2-1:0]; upper address bits are ignored, so addresses wrap.
REQ-006 SHALL, for a read request in cycle N, read the store in cycle N and push {mdata, data} into the read FIFO at the edge ending cycle N.
REQ-007 SHALL, for a write request in cycle N, write the store at the edge ending cycle N and push mdata into the write FIFO; a read in cycle N+1 returns the new data.
REQ-008 SHALL return old data when a read and a write target the same index in the same cycle.
REQ-009 SHALL pop at most one entry per FIFO per cycle, driving that FIFO's rsp_valid high for exactly one cycle per entry; minimum request-to-response latency is 2 cycles.
REQ-010 SHALL handle c0 and c1 independently; simultaneous requests on both are both accepted.
REQ-011 SHALL preserve request order within each channel; there is no ordering between channels.
REQ-012 SHALL assert cX_tx_alm_full combinationally from registered occupancy when free entries <= ALM_FULL_THRESH.
REQ-013 SHALL accept a push into a full FIFO only if a pop occurs in the same cycle; otherwise it drops the request, leaves the store unwritten, and sets ovf.
REQ-014 SHALL hold ovf high until reset once it is set.
REQ-015 SHALL keep rsp_mdata and rsp_data stable only while rsp_valid is high; their values are don't-care otherwise.
REQ-016 SHALL implement a state machine with states INIT and RUN; requests are serviced only in RUN.

Reset
REQ-017 SHALL, while reset_n is low, empty both FIFOs and drive c0_rsp_valid, c1_rsp_valid and ovf to 0.
REQ-018 SHALL drive both alm_full outputs to 1 during reset.
REQ-019 SHALL enter INIT on reset; if reset asserts mid-operation, in-flight responses are discarded and never returned.
REQ-020 SHALL leave store contents unreset unless CCIP_MEM_RSP_INIT_EN is defined.

Configuration
REQ-021 SHALL support macro CCIP_MEM_RSP_INIT_EN. When defined, INIT sweeps the store, writing zero to one index per cycle for 2^DEPTH_LOG2 cycles, then enters RUN. During INIT both alm_full outputs stay 1, and any request is dropped and sets ovf.
REQ-022 SHALL, when CCIP_MEM_RSP_INIT_EN is undefined, leave INIT for RUN on the first clock after reset deasserts; store contents are then undefined until written.

Verification
REQ-023 Write addr 0x5, data 0x32, mdata 0x11, then read addr 0x5, mdata 0x22 -> c1_rsp_mdata 0x11, then c0_rsp_data 0x32 with c0_rsp_mdata 0x22, each at latency 2.
REQ-024 Write addr 0x45 (DEPTH_LOG2=6), data 0xAB; read addr 0x5 -> data 0xAB (wrap).
REQ-025 Same-cycle read and write at addr 0x3; old data 0x1, new data 0x2 -> read returns 0x1; next read returns 0x2.
REQ-026 Issue 9 back-to-back reads with no pops possible (depth 8 held full) -> c0_tx_alm_full high at 6 entries, 9th read dropped, ovf=1 and stays 1.
REQ-027 With CCIP_MEM_RSP_INIT_EN defined: release reset, read addr 0x3F after 64 cycles -> data 0; a read issued at cycle 10 -> dropped, ovf=1.
REQ-028 Assert reset_n low with 3 reads pending -> no c0_rsp_valid after reset deasserts, FIFO empty.
